param_icache: RTL

PARAM_ICACHE -- requirements
Module: param_icache

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/param_icache.sv | 117 +++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the instruction word and the icache fill FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/param_icache.sv
// Direct-mapped instruction cache, NSETS sets of BLKWORDS words each.
// Hits are combinational; a miss fills the whole block from memory one word per ready cycle.
module param_icache #(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    import cpu_types_pkg::*;

    localparam int IDXW = $clog2(NSETS);
    localparam int OFFW = $clog2(BLKWORDS);
    localparam int CNTW = (OFFW > 0) ? OFFW : 1;
    localparam int TAGW = 30 - OFFW - IDXW;
    localparam int AW   = $clog2(NSETS * BLKWORDS);

    icache_state_t   r_state;
    logic [TAGW-1:0] r_fill_tag;
    logic [IDXW-1:0] r_fill_idx;
    logic [CNTW-1:0] r_cnt;
    logic [NSETS-1:0] r_valid;
    logic [TAGW-1:0] r_tags [NSETS];
    word_t           r_data [NSETS*BLKWORDS];

    logic [TAGW-1:0] w_tag;
    logic [IDXW-1:0] w_idx;
    logic [CNTW-1:0] w_off;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_wr_addr;
    logic [31:0]     w_fill_addr;
    logic            w_last;

    // Offset is masked so a one-word block always maps to word 0.
    assign w_off     = CNTW'((imemaddr >> 2) & 32'(BLKWORDS - 1));
    assign w_idx     = IDXW'(imemaddr >> (2 + OFFW));
    assign w_tag     = TAGW'(imemaddr >> (2 + OFFW + IDXW));
    assign w_rd_addr = AW'((32'(w_idx) << OFFW) | 32'(w_off));
    assign w_wr_addr = AW'((32'(r_fill_idx) << OFFW) | (32'(r_cnt) & 32'(BLKWORDS - 1)));
    assign w_fill_addr = ((32'(r_fill_tag) << (IDXW + OFFW))
                        | (32'(r_fill_idx) << OFFW)
                        | (32'(r_cnt) & 32'(BLKWORDS - 1))) << 2;
    assign w_last    = (r_cnt == CNTW'(BLKWORDS - 1));

    assign ihit     = (r_state == IDLE) && imemREN && !iflush
                      && r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign imemload = r_data[w_rd_addr];
    assign iREN     = (r_state == FILL);
    assign iaddr    = (r_state == FILL) ? w_fill_addr : imemaddr;

    // Fill control FSM with valid bits; flush always wins over fill completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_valid    <= '0;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iflush) begin
                        r_valid <= '0;
                    end else if (imemREN && !ihit) begin
                        r_state    <= FILL;
                        r_fill_tag <= w_tag;
                        r_fill_idx <= w_idx;
                        r_cnt      <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FILL: begin
                    if (iflush) begin
                        r_valid <= '0;
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!iwait) begin
                        if (w_last) begin
                            r_valid[r_fill_idx] <= 1'b1;
                            r_state             <= IDLE;
                            r_cnt               <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end else begin
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if ((r_state == FILL) && !iwait) begin
            r_data[w_wr_addr] <= iload;
            if (w_last) begin
                r_tags[r_fill_idx] <= r_fill_tag;
            end
        end
    end

endmodule
